rv32i_decode_stage: RTL

// - RV32I decode stage: turns fetched instruction words into the ALU control encoding alu_func/sub_sra,

---
 rtl/rv_pkg.sv | 73 +++++++
 rtl/rv32i_decode_comb.sv | 116 +++++++++++
 rtl/rv32i_decode_stage.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU / select encodings, the decoded
// bundle handed to execute, and the immediate-format helpers.
package rv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_OP_ADD = 3'd0;
  localparam logic [2:0] ALU_OP_SLL = 3'd1;
  localparam logic [2:0] ALU_OP_XOR = 3'd4;
  localparam logic [2:0] ALU_OP_SR  = 3'd5;
  localparam logic [2:0] ALU_OP_OR  = 3'd6;
  localparam logic [2:0] ALU_OP_AND = 3'd7;

  localparam logic [2:0] RES_SEL_ALU = 3'd0;
  localparam logic [2:0] RES_SEL_LT  = 3'd1;
  localparam logic [2:0] RES_SEL_LTU = 3'd2;
  localparam logic [2:0] RES_SEL_IMM = 3'd3;
  localparam logic [2:0] RES_SEL_PC4 = 3'd4;

  localparam logic OP1_SEL_RS1 = 1'b0;
  localparam logic OP1_SEL_PC  = 1'b1;
  localparam logic OP2_SEL_RS2 = 1'b0;
  localparam logic OP2_SEL_IMM = 1'b1;

  typedef struct packed {
    logic [2:0]  alu_func;
    logic        sub_sra;
    logic        op1_sel;
    logic        op2_sel;
    logic [2:0]  res_sel;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_we;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic [2:0]  funct3;
    logic        illegal;
  } dec_bundle_t;

  function automatic logic [31:0] imm_i(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:25], inst[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] inst);
    return {inst[31:12], 12'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/rv32i_decode_comb.sv
// Purely combinational RV32I instruction decoder: instruction word in,
// decoded control bundle out. No state.
module rv32i_decode_comb
  import rv_pkg::*;
(
  input  logic [31:0] inst,
  output dec_bundle_t dec
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opc = inst[6:0];
  assign f3  = inst[14:12];
  assign f7  = inst[31:25];

  function automatic logic [2:0] slt_sel(input logic [2:0] fn3);
    if (fn3 == 3'd2)      return RES_SEL_LT;
    else if (fn3 == 3'd3) return RES_SEL_LTU;
    else                  return RES_SEL_ALU;
  endfunction

  always_comb begin
    dec          = '0;
    dec.alu_func = ALU_OP_ADD;
    dec.op1_sel  = OP1_SEL_RS1;
    dec.op2_sel  = OP2_SEL_RS2;
    dec.res_sel  = RES_SEL_ALU;
    dec.funct3   = f3;
    dec.rs1      = inst[19:15];
    dec.rs2      = inst[24:20];
    dec.rd       = inst[11:7];

    case (opc)
      OPC_OP: begin
        dec.alu_func = f3;
        dec.sub_sra  = f7[5];
        dec.res_sel  = slt_sel(f3);
        dec.reg_we   = 1'b1;
        if (!(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))))
          dec.illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.alu_func = f3;
        dec.op2_sel  = OP2_SEL_IMM;
        dec.res_sel  = slt_sel(f3);
        dec.reg_we   = 1'b1;
        // shifts carry a 5-bit shamt; the upper bits are the funct7 qualifier
        if (f3 == 3'd1 || f3 == 3'd5) dec.imm = {27'b0, inst[24:20]};
        else                          dec.imm = imm_i(inst);
        if (f3 == 3'd5) dec.sub_sra = inst[30];
        if (f3 == 3'd1 && f7 != 7'h00) dec.illegal = 1'b1;
        if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) dec.illegal = 1'b1;
      end
      OPC_LUI: begin
        dec.res_sel = RES_SEL_IMM;
        dec.imm     = imm_u(inst);
        dec.reg_we  = 1'b1;
      end
      OPC_AUIPC: begin
        dec.op1_sel = OP1_SEL_PC;
        dec.op2_sel = OP2_SEL_IMM;
        dec.imm     = imm_u(inst);
        dec.reg_we  = 1'b1;
      end
      OPC_JAL: begin
        dec.op1_sel = OP1_SEL_PC;
        dec.op2_sel = OP2_SEL_IMM;
        dec.res_sel = RES_SEL_PC4;
        dec.imm     = imm_j(inst);
        dec.reg_we  = 1'b1;
        dec.is_jal  = 1'b1;
      end
      OPC_JALR: begin
        dec.op2_sel = OP2_SEL_IMM;
        dec.res_sel = RES_SEL_PC4;
        dec.imm     = imm_i(inst);
        dec.reg_we  = 1'b1;
        dec.is_jalr = 1'b1;
        if (f3 != 3'd0) dec.illegal = 1'b1;
      end
      OPC_LOAD: begin
        dec.op2_sel = OP2_SEL_IMM;
        dec.imm     = imm_i(inst);
        dec.reg_we  = 1'b1;
        dec.is_load = 1'b1;
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) dec.illegal = 1'b1;
      end
      OPC_STORE: begin
        dec.op2_sel  = OP2_SEL_IMM;
        dec.imm      = imm_s(inst);
        dec.is_store = 1'b1;
        if (f3 > 3'd2) dec.illegal = 1'b1;
      end
      OPC_BRANCH: begin
        dec.imm       = imm_b(inst);
        dec.is_branch = 1'b1;
        if (f3 == 3'd2 || f3 == 3'd3) dec.illegal = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase

    // illegal words still travel down the pipe, but must not have side effects
    if (dec.illegal) begin
      dec.reg_we    = 1'b0;
      dec.is_load   = 1'b0;
      dec.is_store  = 1'b0;
      dec.is_branch = 1'b0;
      dec.is_jal    = 1'b0;
      dec.is_jalr   = 1'b0;
    end
    if (dec.rd == 5'd0) dec.reg_we = 1'b0;
  end

endmodule

// File: rtl/rv32i_decode_stage.sv
// RV32I decode pipeline stage: combinational decode registered into an
// output entry backed by a skid entry, so in_ready comes straight from a flop.
module rv32i_decode_stage
  import rv_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [2:0]      alu_func,
  output logic            sub_sra,
  output logic            op1_sel,
  output logic            op2_sel,
  output logic [2:0]      res_sel,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic            reg_we,
  output logic            is_load,
  output logic            is_store,
  output logic            is_branch,
  output logic            is_jal,
  output logic            is_jalr,
  output logic [2:0]      funct3,
  output logic            illegal
);

  dec_bundle_t     dec_p0;
  dec_bundle_t     out_p1;
  dec_bundle_t     skid_p1;
  dec_bundle_t     view_p1;
  logic [XLEN-1:0] out_pc_p1;
  logic [XLEN-1:0] skid_pc_p1;
  logic            vld_p1;
  logic            skid_vld_p1;
  logic            in_ready_q;

  logic            accept;
  logic            consume;
  logic            vld_nxt;
  logic            skid_vld_nxt;
  logic            load_out;
  logic            load_skid;
  logic            out_from_skid;

  // Stage p0: decode the incoming word
  rv32i_decode_comb u_decode (
    .inst (in_inst),
    .dec  (dec_p0)
  );

  assign accept  = in_valid & in_ready_q;
  assign consume = vld_p1 & out_ready;

  always_comb begin
    vld_nxt       = vld_p1;
    skid_vld_nxt  = skid_vld_p1;
    load_out      = 1'b0;
    load_skid     = 1'b0;
    out_from_skid = 1'b0;
    if (flush) begin
      vld_nxt      = 1'b0;
      skid_vld_nxt = 1'b0;
    end else if (consume) begin
      // in_ready is low whenever the skid entry is full, so no accept here
      if (skid_vld_p1) begin
        out_from_skid = 1'b1;
        skid_vld_nxt  = 1'b0;
      end else begin
        vld_nxt  = accept;
        load_out = accept;
      end
    end else if (!vld_p1) begin
      vld_nxt  = accept;
      load_out = accept;
    end else if (accept) begin
      load_skid    = 1'b1;
      skid_vld_nxt = 1'b1;
    end
  end

  // Stage p1: output / skid entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      vld_p1      <= vld_nxt;
      skid_vld_p1 <= skid_vld_nxt;
      in_ready_q  <= !skid_vld_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (load_out) begin
      out_p1    <= dec_p0;
      out_pc_p1 <= in_pc;
    end else if (out_from_skid) begin
      out_p1    <= skid_p1;
      out_pc_p1 <= skid_pc_p1;
    end
    if (load_skid) begin
      skid_p1    <= dec_p0;
      skid_pc_p1 <= in_pc;
    end
  end

  // payload reads as zero while the stage is empty, including right after reset
  assign view_p1   = vld_p1 ? out_p1 : '0;
  assign out_pc    = vld_p1 ? out_pc_p1 : RESET_PC;
  assign out_valid = vld_p1;
  assign in_ready  = in_ready_q;

  assign alu_func  = view_p1.alu_func;
  assign sub_sra   = view_p1.sub_sra;
  assign op1_sel   = view_p1.op1_sel;
  assign op2_sel   = view_p1.op2_sel;
  assign res_sel   = view_p1.res_sel;
  assign imm       = view_p1.imm;
  assign rs1       = view_p1.rs1;
  assign rs2       = view_p1.rs2;
  assign rd        = view_p1.rd;
  assign reg_we    = view_p1.reg_we;
  assign is_load   = view_p1.is_load;
  assign is_store  = view_p1.is_store;
  assign is_branch = view_p1.is_branch;
  assign is_jal    = view_p1.is_jal;
  assign is_jalr   = view_p1.is_jalr;
  assign funct3    = view_p1.funct3;
  assign illegal   = view_p1.illegal;

endmodule
